// File: rtl/sin_lut_arb_pkg.sv
// Shared widths and types for the sine LUT arbiter slice.
// Defaults match the 512 x 16 sine ROM feeding four tone voices.
package sin_lut_arb_pkg;

    localparam int N_REQ_DEF     = 4;
    localparam int ADDR_BITS_DEF = 9;
    localparam int SIG_BITS_DEF  = 16;
    localparam int ROM_LAT_DEF   = 1;

    typedef logic [ADDR_BITS_DEF-1:0]      lut_addr_t;
    typedef logic [SIG_BITS_DEF-1:0]       lut_data_t;
    typedef logic [$clog2(N_REQ_DEF)-1:0]  voice_id_t;

    // Width of an encoded voice index; never narrower than one bit.
    function automatic int id_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sin_lut_arb_rr_arbiter.sv
// Round-robin arbiter: pointer register plus one-hot grant and encoded winner id.
// Latency: grant is combinational from req and pointer; pointer updates on the grant edge.
// Backpressure: none; a requester simply waits until the rotating search reaches it.
module sin_lut_arb_rr_arbiter
    import sin_lut_arb_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    localparam int ID_W  = id_bits(N_REQ)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_vld,
    output logic [ID_W-1:0]  gnt_id
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] idx;

    // Grants are held off while reset is asserted so no transfer is accepted then.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = ID_W'((int'(ptr) + off) % N_REQ);
            if (!gnt_vld && reset_n && req[idx]) begin
                gnt_vld  = 1'b1;
                gnt_id   = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (gnt_vld) begin
            ptr <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/sin_lut_arb.sv
// Shares one synchronous sine ROM among N_REQ voices and returns tagged samples in grant order.
// Latency: grant to rd_valid is 2+ROM_LAT cycles; one lookup per cycle aggregate.
// Backpressure: none; voices wait on gnt, returned samples cannot be stalled.
module sin_lut_arb
    import sin_lut_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int SIG_BITS  = SIG_BITS_DEF,
    parameter int ROM_LAT   = ROM_LAT_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*ADDR_BITS-1:0] addr,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           rd_valid,
    output logic [SIG_BITS-1:0]        rd_data,
    output logic                       rom_rd,
    output logic [ADDR_BITS-1:0]       rom_addr,
    input  logic [SIG_BITS-1:0]        rom_q
);

    localparam int ID_W = id_bits(N_REQ);

    logic                 gnt_vld;
    logic [ID_W-1:0]      gnt_id;
    logic [ADDR_BITS-1:0] sel_addr;
    logic [N_REQ-1:0]     ret_onehot;

    // Stage 0 is aligned with rom_rd; stage ROM_LAT is aligned with valid rom_q.
    logic [ROM_LAT:0]     vld_sr;
    logic [ID_W-1:0]      id_sr [ROM_LAT+1];

    sin_lut_arb_rr_arbiter #(
        .N_REQ   (N_REQ)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    assign sel_addr   = addr[int'(gnt_id)*ADDR_BITS +: ADDR_BITS];
    assign ret_onehot = N_REQ'(1) << id_sr[ROM_LAT];
    assign rom_rd     = vld_sr[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
            vld_sr   <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                id_sr[i] <= '0;
            end
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            if (gnt_vld) begin
                rom_addr <= sel_addr;
            end
            vld_sr   <= {vld_sr[ROM_LAT-1:0], gnt_vld};
            id_sr[0] <= gnt_id;
            for (int i = 1; i <= ROM_LAT; i++) begin
                id_sr[i] <= id_sr[i-1];
            end
            rd_valid <= vld_sr[ROM_LAT] ? ret_onehot : '0;
            if (vld_sr[ROM_LAT]) begin
                rd_data <= rom_q;
            end
        end
    end

endmodule

// File: tb/tb_sin_lut_arb.sv
// Bench for sin_lut_arb: ROM_LAT=1 and ROM_LAT=3 instances share stimulus and are
// compared every cycle against a queue-based round-robin reference model.
module tb_sin_lut_arb;
    import sin_lut_arb_pkg::*;

    localparam int N  = 4;
    localparam int AB = 9;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic [3:0]    req     = '0;
    logic [35:0]   addr    = '0;

    logic [3:0]    gnt1, gnt3, rv1, rv3;
    lut_data_t     rd1, rd3, q1, q3;
    logic          rr1, rr3;
    lut_addr_t     ra1, ra3;
    lut_data_t     p3 [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    int        m_ptr;
    logic      pend_rd;
    lut_addr_t pend_addr;
    logic      exp_rr;
    lut_addr_t exp_ra;
    logic [3:0] exp_gnt, exp_rv1, exp_rv3;
    lut_data_t exp_rd1, exp_rd3, last1, last3;
    int        due1_v [int];
    int        due3_v [int];
    lut_data_t due1_d [int];
    lut_data_t due3_d [int];

    always #5 clk = ~clk;

    function automatic lut_data_t lut(input lut_addr_t a);
        logic [15:0] x;
        x = {7'd0, a};
        return (x * 16'd40503) ^ 16'h5A5A;
    endfunction

    always @(posedge clk) q1 <= lut(ra1);
    always @(posedge clk) begin
        p3[0] <= lut(ra3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign q3 = p3[2];

    sin_lut_arb #(.N_REQ(4), .ADDR_BITS(9), .SIG_BITS(16), .ROM_LAT(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .req(req), .addr(addr), .gnt(gnt1),
        .rd_valid(rv1), .rd_data(rd1), .rom_rd(rr1), .rom_addr(ra1), .rom_q(q1)
    );

    sin_lut_arb #(.N_REQ(4), .ADDR_BITS(9), .SIG_BITS(16), .ROM_LAT(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .req(req), .addr(addr), .gnt(gnt3),
        .rd_valid(rv3), .rd_data(rd3), .rom_rd(rr3), .rom_addr(ra3), .rom_q(q3)
    );

    function automatic logic [67:0] obs();
        return {gnt1, gnt3, rr1, ra1, rr3, ra3, rv1, rd1, rv3, rd3};
    endfunction

    function automatic logic [67:0] expv();
        return {exp_gnt, exp_gnt, exp_rr, exp_ra, exp_rr, exp_ra, exp_rv1, exp_rd1, exp_rv3, exp_rd3};
    endfunction

    function automatic lut_addr_t rand_addr();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return 9'h1FF;
            default: return 9'($urandom);
        endcase
    endfunction

    function automatic logic [35:0] rand_addrs();
        return {rand_addr(), rand_addr(), rand_addr(), rand_addr()};
    endfunction

    // One clock of stimulus; the model predicts what is visible at the following negedge.
    task automatic step(input logic rn, input logic [3:0] r, input logic [35:0] a);
        @(posedge clk);
        #1;
        reset_n = rn;
        req     = r;
        addr    = a;
        exp_gnt = '0;
        if (!rn) begin
            m_ptr = 0; pend_rd = 1'b0; pend_addr = '0;
            exp_rr = 1'b0; exp_ra = '0; last1 = '0; last3 = '0;
            due1_v.delete(); due1_d.delete(); due3_v.delete(); due3_d.delete();
        end else begin
            exp_rr = pend_rd;
            if (pend_rd) exp_ra = pend_addr;
            pend_rd = 1'b0;
            for (int o = 0; o < N; o++) begin
                automatic int v = (m_ptr + o) % N;
                if (!pend_rd && r[v]) begin
                    exp_gnt[v] = 1'b1;
                    pend_rd    = 1'b1;
                    pend_addr  = a[v*AB +: AB];
                    m_ptr      = (v + 1) % N;
                    due1_v[cyc+3] = v; due1_d[cyc+3] = lut(pend_addr);
                    due3_v[cyc+5] = v; due3_d[cyc+5] = lut(pend_addr);
                end
            end
        end
        exp_rv1 = '0;
        if (due1_v.exists(cyc)) begin exp_rv1[due1_v[cyc]] = 1'b1; last1 = due1_d[cyc]; end
        exp_rd1 = last1;
        exp_rv3 = '0;
        if (due3_v.exists(cyc)) begin exp_rv3[due3_v[cyc]] = 1'b1; last3 = due3_d[cyc]; end
        exp_rd3 = last3;
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 4'($urandom), rand_addrs());
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL reset_asserted cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'b0000, rand_addrs());
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
        checks++;
        if ({gnt1, rr1, ra1, rv1, rd1} !== '0) begin
            errors++;
            $display("FAIL reset_zero got=%h want=0", {gnt1, rr1, ra1, rv1, rd1});
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < 14; i++) begin
            logic [35:0] a;
            a = rand_addrs();
            a[8:0] = 9'h0FF;
            step(1'b1, (i < 8) ? 4'b0001 : 4'b0000, a);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL single_voice cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
            if (i >= 3 && i < 11) begin
                checks++;
                if (rv1 !== 4'b0001 || rd1 !== lut(9'h0FF)) begin
                    errors++;
                    $display("FAIL single_return cyc=%0d got=%b/%h want=0001/%h", cyc, rv1, rd1, lut(9'h0FF));
                end
            end
        end
    endtask

    task automatic test_all();
        step(1'b0, 4'b0000, '0);
        for (int i = 0; i < 18; i++) begin
            step(1'b1, (i < 12) ? 4'b1111 : 4'b0000, {9'd384, 9'd256, 9'd128, 9'd0});
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL all_voices cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
            if (i < 12) begin
                checks++;
                if (gnt1 !== (4'b0001 << (i % 4))) begin
                    errors++;
                    $display("FAIL rr_order cyc=%0d got=%b want=%b", cyc, gnt1, 4'b0001 << (i % 4));
                end
            end
        end
    endtask

    task automatic test_withdraw();
        int seen1;
        logic [3:0] pat [3];
        pat[0] = 4'b0010; pat[1] = 4'b0011; pat[2] = 4'b0011;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, (i < 3) ? pat[i] : 4'b0000, rand_addrs());
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL ptr_two cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
            if (i == 1 || i == 2) begin
                checks++;
                if (gnt1 !== ((i == 1) ? 4'b0001 : 4'b0010)) begin
                    errors++;
                    $display("FAIL ptr_two_gnt cyc=%0d got=%b want=%b", cyc, gnt1, (i == 1) ? 4'b0001 : 4'b0010);
                end
            end
        end
        seen1 = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, (i == 0) ? 4'b0011 : (i == 1) ? 4'b0001 : 4'b0000, rand_addrs());
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL withdraw cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
            if (rv1[1] || rv3[1] || gnt1[1]) seen1++;
        end
        checks++;
        if (seen1 !== 0) begin
            errors++;
            $display("FAIL withdraw_voice1 got=%0d events want=0", seen1);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, rand_addrs());
        step(1'b0, 4'b1111, rand_addrs());
        checks++;
        if ({gnt1, gnt3, rr1, rr3, ra1, rv1, rv3, rd1, rd3} !== '0) begin
            errors++;
            $display("FAIL reset_mid_zero got=%h want=0", {gnt1, gnt3, rr1, rr3, ra1, rv1, rv3, rd1, rd3});
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 0) ? 4'b1111 : 4'b0000, rand_addrs());
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL reset_mid cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
            if (i == 0) begin
                checks++;
                if (gnt1 !== 4'b0001) begin
                    errors++;
                    $display("FAIL reset_mid_gnt got=%b want=0001", gnt1);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'b1, (i < 390) ? 4'($urandom) : 4'b0000, rand_addrs());
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
    endtask

    initial begin
        m_ptr = 0; pend_rd = 1'b0; pend_addr = '0;
        exp_rr = 1'b0; exp_ra = '0; last1 = '0; last3 = '0;
        test_reset();
        test_single();
        test_all();
        test_withdraw();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
